fp16_pack_round: RTL and testbench
==================================

Name: fp16_pack_round

Overview:
- Output stage of fma16: inverse of the operand unpacker.
- Takes the unrounded sign/exponent/mantissa and special-case flags from the adder, then normalizes, rounds and packs them into an IEEE-754 binary16 word with exception flags.
- Two-stage pipeline with valid/ready handshakes on both sides, so it can drain into a stalled consumer without losing results.

Parameters:
- NF, 10, stored fraction width
- NE, 5, stored exponent width
- MW, 22, input mantissa width; binary point between bits MW-2 and MW-3, value range [0,4)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- in_valid  in  1  input beat valid
- in_ready  out  1  block can accept a beat this cycle
- Zs  in  1  result sign
- Ze  in  8  signed biased exponent (bias 15); value = Zm * 2^(Ze-15)
- Zm  in  22  unrounded mantissa
- Zsticky  in  1  OR of mantissa bits already discarded upstream
- Zzero  in  1  exact zero result
- Zinf  in  1  infinite result
- Znan  in  1  NaN result
- Zinvalid  in  1  invalid-operation event (sNaN input or inf*0 / inf-inf)
- rm  in  2  rounding mode: 00 RZ, 01 RNE, 10 RD (toward -inf), 11 RU (toward +inf)
- out_valid  out  1  Result valid
- out_ready  in  1  consumer accepts Result
- Result  out  16  packed binary16
- Flags  out  4  {invalid, overflow, underflow, inexact}

Behaviour:
- Reset: out_valid=0, stage-1 valid=0, Result=16'h0000, Flags=4'h0. Reset mid-stall discards all in-flight beats.
- Handshake and stage enables:
  - s2_en = ~out_valid | out_ready
  - s1_en = ~s1_valid | s2_en
  - in_ready = s1_en
  - Beat accepted when in_valid & in_ready.
  - Latency is 2 cycles when unstalled; throughput is 1 per cycle; order is preserved.
  - Outputs hold stable while out_valid & ~out_ready.
  - The only combinational path is out_ready -> in_ready; there is no in->out path.
- Stage 1, normalize (registers sign, exponent, shifted mantissa, guard/sticky, specials, rm):
  - Zm[21]=1: shift right 1, exponent+1; the shifted-out bit joins sticky.
  - Otherwise, with lzc = leading zeros of Zm[20:0]:
    - Ze > 1: left shift by min(lzc, Ze-1), exponent minus that amount. Exponent 1 with a leading 0 denotes subnormal.
    - Ze <= 0: right shift by min(1-Ze, 24), exponent=1 (subnormal scale); all shifted-out bits OR into sticky.
    - Zm == 0 with no special flag: treated as zero.
- Stage 2, round and pack:
  - L = fraction LSB; G = next bit; S = OR of remaining bits | Zsticky.
  - Increment: RNE G&(L|S); RZ never; RD Zs&(G|S); RU ~Zs&(G|S).
  - Mantissa carry-out: exponent+1, fraction=0. A subnormal rounding up to 1.0 becomes min normal (exp field 1).
  - Leading bit 0 after rounding: exp field 0.
  - Overflow when final exponent >= 31:
    - RNE: ±inf (7C00/FC00).
    - RZ: ±7BFF.
    - RU: +inf / -7BFF (FBFF).
    - RD: +7BFF / -inf.
    - Sets overflow and inexact.
  - inexact = G|S (or overflow).
  - underflow = result subnormal or zero after rounding from a nonzero value, AND inexact (tininess after rounding).
- Specials take precedence over datapath, in order Znan > Zinf > Zzero:
  - NaN: Result=7E00 (canonical qNaN).
  - Inf: {Zs,7C00}.
  - Zero: {Zs,0000}.
  - Overflow, underflow and inexact are 0 for specials.
  - invalid = Zinvalid in all cases.

Decomposition:
- fma16_pkg holds:
  - rm enum (RZ, RNE, RD, RU)
  - BIAS=15
  - QNAN=16'h7E00
  - INF_EXP=5'h1F
  - MAXNORM=15'h7BFF
  - flag bit indices
- Sub-module lzc22: combinational leading-zero counter, 22 in / 5 out; the unpacker reuses it for subnormal prenormalization.

Test Plan:
- Zs=0, Ze=15, Zm=22'h100000, rm=RNE, out_ready=1 -> Result 3C00, Flags 0, out_valid exactly 2 cycles after accept.
- Ze=15, rm=RNE: Zm=22'h100200 -> 3C00 with inexact (tie to even); Zm=22'h100600 -> 3C02 with inexact.
- Ze=31, Zm=22'h100000, Zs=0 -> RNE 7C00 Flags{0,1,0,1}; RZ 7BFF; Zs=1, RU -> FBFF.
- Subnormal and underflow:
  - Ze=0, Zm=22'h100000 -> 0200 exact, underflow=0.
  - Ze=-20, Zm=22'h100000, RNE -> 0000, underflow+inexact.
  - Same input with RU -> 0001.
- Specials:
  - Znan=1, Zinvalid=1 -> 7E00 Flags{1,0,0,0}.
  - Zinf=1, Zs=1 -> FC00 Flags 0.
  - Zzero=1, Zs=1 -> 8000.
- Backpressure: out_ready=0, 3 back-to-back beats -> 2 accepted, in_ready=0 on the third. Release out_ready -> all 3 results emerge in order, none dropped or duplicated. Reset asserted while stalled -> out_valid=0 next cycle.

Source files
------------

// File: rtl/fma16_pkg.sv
// Shared types and constants for the fma16 datapath (unpack / pack stages).
package fma16_pkg;

    localparam int unsigned NF   = 10;          // stored fraction width
    localparam int unsigned NE   = 5;           // stored exponent width
    localparam int unsigned MW   = 22;          // unrounded mantissa width, value in [0,4)
    localparam int unsigned EW   = 8;           // signed biased exponent width from the adder
    localparam int unsigned XW   = 10;          // internal exponent width, headroom for carries
    localparam int unsigned BIAS = 15;

    localparam logic [15:0]   QNAN    = 16'h7E00;
    localparam logic [NE-1:0] INF_EXP = 5'h1F;
    localparam logic [14:0]   MAXNORM = 15'h7BFF;

    localparam int unsigned FLAG_INVALID   = 3;
    localparam int unsigned FLAG_OVERFLOW  = 2;
    localparam int unsigned FLAG_UNDERFLOW = 1;
    localparam int unsigned FLAG_INEXACT   = 0;

    typedef enum logic [1:0] {
        RM_RZ  = 2'b00,
        RM_RNE = 2'b01,
        RM_RD  = 2'b10,
        RM_RU  = 2'b11
    } rm_e;

    // Normalized beat held between the normalize and round stages.
    typedef struct packed {
        logic          sign;
        logic [XW-1:0] exp;
        logic [MW-1:0] man;
        logic          sticky;
        logic          nan;
        logic          inf;
        logic          zero;
        logic          invalid;
        rm_e           rm;
    } s1_t;

endpackage

// File: rtl/fp16_pack_round_if.sv
// Upstream beat and downstream result handshake bundle for fp16_pack_round.
interface fp16_pack_round_if;
    import fma16_pkg::*;

    logic          in_valid;
    logic          in_ready;
    logic          Zs;
    logic [EW-1:0] Ze;
    logic [MW-1:0] Zm;
    logic          Zsticky;
    logic          Zzero;
    logic          Zinf;
    logic          Znan;
    logic          Zinvalid;
    rm_e           rm;
    logic          out_valid;
    logic          out_ready;
    logic [15:0]   Result;
    logic [3:0]    Flags;

    modport master (
        output in_valid, Zs, Ze, Zm, Zsticky, Zzero, Zinf, Znan, Zinvalid, rm, out_ready,
        input  in_ready, out_valid, Result, Flags
    );

    modport slave (
        input  in_valid, Zs, Ze, Zm, Zsticky, Zzero, Zinf, Znan, Zinvalid, rm, out_ready,
        output in_ready, out_valid, Result, Flags
    );

endinterface

// File: rtl/lzc22.sv
// Combinational leading-zero counter, 22 bits in; returns 22 for an all-zero input.
module lzc22 (
    input  logic [21:0] a,
    output logic [4:0]  cnt
);

    // Highest set bit wins because later iterations overwrite earlier ones.
    always_comb begin
        cnt = 5'd22;
        for (int i = 0; i < 22; i++) begin
            if (a[i]) cnt = 5'(21 - i);
        end
    end

endmodule

// File: rtl/fp16_pack_round.sv
// fma16 output stage: normalize, round and pack into binary16 with exception flags.
module fp16_pack_round
    import fma16_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    fp16_pack_round_if.slave   bus
);

    logic          s2_en;
    logic          s1_en;

    logic          s1_valid_q, s1_valid_d;
    s1_t           s1_q, s1_d;
    logic          out_valid_q, out_valid_d;
    logic [15:0]   result_q, result_d;
    logic [3:0]    flags_q, flags_d;

    s1_t           nrm;
    logic [MW-1:0] m0;
    logic [XW-1:0] e0;
    logic          st0;
    logic [4:0]    lzc_cnt;
    logic [4:0]    lz;
    logic [XW-1:0] emax;
    logic [XW-1:0] rsh;
    logic [4:0]    shamt;
    logic [MW+23:0] wide;

    logic          lead, l_bit, g_bit, s_bit, inc;
    logic [NF-1:0] frac;
    logic [NF+1:0] sum;
    logic          carry, lead_r, ovf, inexact;
    logic [NF-1:0] frac_r;
    logic [XW-1:0] e_r;
    logic [15:0]   res;
    logic [3:0]    flg;

    assign s2_en        = ~out_valid_q | bus.out_ready;
    assign s1_en        = ~s1_valid_q | s2_en;
    assign bus.in_ready  = s1_en;
    assign bus.out_valid = out_valid_q;
    assign bus.Result    = result_q;
    assign bus.Flags     = flags_q;

    lzc22 u_lzc (
        .a   (m0),
        .cnt (lzc_cnt)
    );

    // Stage 1: fold the [2,4) case down, then left-normalize or denormalize to exponent 1.
    always_comb begin
        m0    = bus.Zm[MW-1] ? {1'b0, bus.Zm[MW-1:1]} : bus.Zm;
        e0    = {{(XW-EW){bus.Ze[EW-1]}}, bus.Ze} + XW'(bus.Zm[MW-1]);
        st0   = bus.Zsticky | (bus.Zm[MW-1] & bus.Zm[0]);
        lz    = lzc_cnt - 5'd1;     // m0[MW-1] is always clear, so count over the low 21 bits
        emax  = e0 - XW'(1);
        rsh   = XW'(1) - e0;
        shamt = '0;
        wide  = '0;

        nrm         = '0;
        nrm.sign    = bus.Zs;
        nrm.nan     = bus.Znan;
        nrm.inf     = bus.Zinf;
        nrm.zero    = bus.Zzero | (bus.Zm == '0);
        nrm.invalid = bus.Zinvalid;
        nrm.rm      = bus.rm;
        nrm.sticky  = st0;
        nrm.man     = m0;
        nrm.exp     = e0;

        if (!e0[XW-1] && (e0 != '0)) begin
            shamt   = (emax < XW'(lz)) ? emax[4:0] : lz;
            nrm.man = m0 << shamt;
            nrm.exp = e0 - XW'(shamt);
        end else begin
            if (rsh > XW'(24)) rsh = XW'(24);
            wide       = {m0, 24'b0} >> rsh;
            nrm.man    = wide[MW+23:24];
            nrm.sticky = st0 | (|wide[23:0]);
            nrm.exp    = XW'(1);
        end
    end

    // Stage 1 register load: advance whenever the slot is empty or stage 2 drains.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_d       = s1_q;
        if (s1_en) begin
            s1_valid_d = bus.in_valid;
            s1_d       = nrm;
        end
    end

    // Stage 2: round by mode, detect overflow/underflow, then let specials override.
    always_comb begin
        lead  = |s1_q.man[MW-1:MW-2];   // bit MW-1 is always clear after normalization
        frac  = s1_q.man[MW-3 -: NF];
        l_bit = frac[0];
        g_bit = s1_q.man[MW-3-NF];
        s_bit = (|s1_q.man[MW-4-NF:0]) | s1_q.sticky;

        inc = 1'b0;
        case (s1_q.rm)
            RM_RZ:   inc = 1'b0;
            RM_RNE:  inc = g_bit & (l_bit | s_bit);
            RM_RD:   inc = s1_q.sign & (g_bit | s_bit);
            RM_RU:   inc = ~s1_q.sign & (g_bit | s_bit);
            default: inc = 1'b0;
        endcase

        sum     = (NF+2)'({lead, frac}) + (NF+2)'(inc);
        carry   = sum[NF+1];
        lead_r  = carry | sum[NF];
        frac_r  = carry ? '0 : sum[NF-1:0];
        e_r     = s1_q.exp + XW'(carry);
        ovf     = lead_r & (e_r >= XW'(2*BIAS + 1));
        inexact = g_bit | s_bit | ovf;

        res = lead_r ? {s1_q.sign, e_r[NE-1:0], frac_r} : {s1_q.sign, NE'(0), frac_r};
        flg = '0;
        flg[FLAG_INEXACT]   = inexact;
        flg[FLAG_UNDERFLOW] = ~lead_r & inexact;

        if (ovf) begin
            flg[FLAG_OVERFLOW] = 1'b1;
            case (s1_q.rm)
                RM_RNE:  res = {s1_q.sign, INF_EXP, NF'(0)};
                RM_RZ:   res = {s1_q.sign, MAXNORM};
                RM_RU:   res = s1_q.sign ? {1'b1, MAXNORM} : {1'b0, INF_EXP, NF'(0)};
                RM_RD:   res = s1_q.sign ? {1'b1, INF_EXP, NF'(0)} : {1'b0, MAXNORM};
                default: res = {s1_q.sign, INF_EXP, NF'(0)};
            endcase
        end

        if (s1_q.nan) begin
            res = QNAN;
            flg = '0;
        end else if (s1_q.inf) begin
            res = {s1_q.sign, INF_EXP, NF'(0)};
            flg = '0;
        end else if (s1_q.zero) begin
            res = {s1_q.sign, 15'h0000};
            flg = '0;
        end
        flg[FLAG_INVALID] = s1_q.invalid;
    end

    // Output register load: hold while the consumer stalls a valid result.
    always_comb begin
        out_valid_d = out_valid_q;
        result_d    = result_q;
        flags_d     = flags_q;
        if (s2_en) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                result_d = res;
                flags_d  = flg;
            end
        end
    end

    // Pipeline state; reset discards every in-flight beat.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_q  <= 1'b0;
            s1_q        <= '0;
            out_valid_q <= 1'b0;
            result_q    <= 16'h0000;
            flags_q     <= 4'h0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_q        <= s1_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            flags_q     <= flags_d;
        end
    end

endmodule

// File: tb/tb_fp16_pack_round.sv
// Directed bench for fp16_pack_round: rounding, specials, overflow/underflow and backpressure.
module tb_fp16_pack_round;
    import fma16_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;

    fp16_pack_round_if bus ();

    fp16_pack_round u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // One beat through an unstalled pipe: latency, result and flags.
    task automatic run_vec(input string tag, input logic zs, input logic [7:0] ze,
                           input logic [21:0] zm, input logic zst, input logic zzero,
                           input logic zinf, input logic znan, input logic zinv,
                           input rm_e r, input logic [15:0] er, input logic [3:0] ef);
        int edges;
        bus.Zs = zs; bus.Ze = ze; bus.Zm = zm; bus.Zsticky = zst;
        bus.Zzero = zzero; bus.Zinf = zinf; bus.Znan = znan; bus.Zinvalid = zinv;
        bus.rm = r; bus.out_ready = 1'b1; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        edges = 1;
        while (!bus.out_valid && edges < 8) begin
            @(posedge clk); #1;
            edges++;
        end
        chk({tag, ".lat"}, 32'(edges), 32'd2);
        chk({tag, ".res"}, 32'(bus.Result), 32'(er));
        chk({tag, ".flg"}, 32'(bus.Flags), 32'(ef));
        @(posedge clk); #1;
    endtask

    logic [15:0] got[$];
    logic [15:0] obs16;
    logic [15:0] exp_bp [3];
    int          n_acc;
    logic        acc;

    initial begin
        bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.Zs = 1'b0; bus.Ze = '0; bus.Zm = '0;
        bus.Zsticky = 1'b0; bus.Zzero = 1'b0; bus.Zinf = 1'b0; bus.Znan = 1'b0;
        bus.Zinvalid = 1'b0; bus.rm = RM_RNE;

        repeat (3) @(posedge clk);
        #1;
        chk("rst.out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst.result", 32'(bus.Result), 32'h0000);
        chk("rst.flags", 32'(bus.Flags), 32'h0);
        chk("rst.in_ready", 32'(bus.in_ready), 32'd1);
        reset = 1'b0;
        @(posedge clk); #1;

        //       tag           Zs  Ze     Zm            st zr in nn iv rm      Result    Flags
        run_vec("one",        0, 8'd15, 22'h100000, 0, 0, 0, 0, 0, RM_RNE, 16'h3C00, 4'h0);
        run_vec("tie_even",   0, 8'd15, 22'h100200, 0, 0, 0, 0, 0, RM_RNE, 16'h3C00, 4'h1);
        run_vec("tie_up",     0, 8'd15, 22'h100600, 0, 0, 0, 0, 0, RM_RNE, 16'h3C02, 4'h1);
        run_vec("rd_neg",     1, 8'd15, 22'h100200, 0, 0, 0, 0, 0, RM_RD,  16'hBC01, 4'h1);
        run_vec("half",       0, 8'd15, 22'h080000, 0, 0, 0, 0, 0, RM_RNE, 16'h3800, 4'h0);
        run_vec("two",        0, 8'd15, 22'h200000, 0, 0, 0, 0, 0, RM_RNE, 16'h4000, 4'h0);
        run_vec("two_st",     0, 8'd15, 22'h200001, 0, 0, 0, 0, 0, RM_RNE, 16'h4000, 4'h1);
        run_vec("carry",      0, 8'd15, 22'h1FFE00, 0, 0, 0, 0, 0, RM_RNE, 16'h4000, 4'h1);
        run_vec("ovf_rne",    0, 8'd31, 22'h100000, 0, 0, 0, 0, 0, RM_RNE, 16'h7C00, 4'h5);
        run_vec("ovf_rz",     0, 8'd31, 22'h100000, 0, 0, 0, 0, 0, RM_RZ,  16'h7BFF, 4'h5);
        run_vec("ovf_ru_neg", 1, 8'd31, 22'h100000, 0, 0, 0, 0, 0, RM_RU,  16'hFBFF, 4'h5);
        run_vec("ovf_round",  0, 8'd30, 22'h1FFE00, 0, 0, 0, 0, 0, RM_RNE, 16'h7C00, 4'h5);
        run_vec("sub_exact",  0, 8'd0,  22'h100000, 0, 0, 0, 0, 0, RM_RNE, 16'h0200, 4'h0);
        run_vec("tiny_rne",   0, 8'hEC, 22'h100000, 0, 0, 0, 0, 0, RM_RNE, 16'h0000, 4'h3);
        run_vec("tiny_ru",    0, 8'hEC, 22'h100000, 0, 0, 0, 0, 0, RM_RU,  16'h0001, 4'h3);
        run_vec("min_norm",   0, 8'd1,  22'h0FFE00, 0, 0, 0, 0, 0, RM_RNE, 16'h0400, 4'h1);
        run_vec("sticky_in",  0, 8'd15, 22'h100000, 1, 0, 0, 0, 0, RM_RU,  16'h3C01, 4'h1);
        run_vec("nan",        0, 8'd15, 22'h100000, 0, 0, 0, 1, 1, RM_RNE, 16'h7E00, 4'h8);
        run_vec("inf_neg",    1, 8'd15, 22'h100000, 0, 0, 1, 0, 0, RM_RNE, 16'hFC00, 4'h0);
        run_vec("inf_inv",    0, 8'd15, 22'h100000, 0, 0, 1, 0, 1, RM_RNE, 16'h7C00, 4'h8);
        run_vec("zero_neg",   1, 8'd15, 22'h100000, 0, 1, 0, 0, 0, RM_RNE, 16'h8000, 4'h0);
        run_vec("zm_zero",    0, 8'd15, 22'h000000, 0, 0, 0, 0, 0, RM_RNE, 16'h0000, 4'h0);

        // Backpressure: three back-to-back beats into a stalled consumer.
        exp_bp[0] = 16'h3C00; exp_bp[1] = 16'h3C02; exp_bp[2] = 16'h3800;
        n_acc = 0;
        bus.out_ready = 1'b0; bus.rm = RM_RNE; bus.Zs = 1'b0; bus.Zsticky = 1'b0;
        bus.Zzero = 1'b0; bus.Zinf = 1'b0; bus.Znan = 1'b0; bus.Zinvalid = 1'b0;
        bus.Ze = 8'd15; bus.Zm = 22'h100000; bus.in_valid = 1'b1; #1;
        chk("bp.rdy_a", 32'(bus.in_ready), 32'd1);
        if (bus.in_ready) n_acc++;
        @(posedge clk); #1;
        bus.Zm = 22'h100600;
        chk("bp.rdy_b", 32'(bus.in_ready), 32'd1);
        if (bus.in_ready) n_acc++;
        @(posedge clk); #1;
        bus.Ze = 8'd14; bus.Zm = 22'h100000;
        chk("bp.rdy_c", 32'(bus.in_ready), 32'd0);
        if (bus.in_ready) n_acc++;
        chk("bp.accepted", 32'(n_acc), 32'd2);
        chk("bp.valid", 32'(bus.out_valid), 32'd1);
        @(posedge clk); #1;
        chk("bp.hold_res", 32'(bus.Result), 32'h3C00);
        chk("bp.hold_rdy", 32'(bus.in_ready), 32'd0);

        bus.out_ready = 1'b1; #1;
        for (int c = 0; c < 20 && got.size() < 3; c++) begin
            if (bus.out_valid && bus.out_ready) got.push_back(bus.Result);
            acc = bus.in_valid && bus.in_ready;
            @(posedge clk); #1;
            if (acc) bus.in_valid = 1'b0;
        end
        chk("bp.count", 32'(got.size()), 32'd3);
        for (int i = 0; i < 3; i++) begin
            obs16 = (i < got.size()) ? got[i] : 16'hDEAD;
            chk($sformatf("bp.order%0d", i), 32'(obs16), 32'(exp_bp[i]));
        end
        chk("bp.drained", 32'(bus.out_valid), 32'd0);

        // Reset while stalled with both stages occupied.
        bus.out_ready = 1'b0; bus.Ze = 8'd15; bus.Zm = 22'h100000; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.Zm = 22'h100600;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        chk("rs.stalled", 32'(bus.out_valid), 32'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("rs.out_valid", 32'(bus.out_valid), 32'd0);
        chk("rs.result", 32'(bus.Result), 32'h0000);
        chk("rs.flags", 32'(bus.Flags), 32'h0);
        reset = 1'b0; bus.out_ready = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("rs.no_stale", 32'(bus.out_valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
